// File: rtl/calc_pkg.sv
// Shared constants for the 8-bit calculator front-ends: opcodes, strobe bit
// positions in the calculator's {add,sub,mul,and,or,not,xor} bus, and FSM state codes.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  localparam int unsigned NumStb = 7;

  // Bit 6 is the leftmost strobe (add), bit 0 the rightmost (xor).
  localparam int unsigned STB_ADD = 6;
  localparam int unsigned STB_SUB = 5;
  localparam int unsigned STB_MUL = 4;
  localparam int unsigned STB_AND = 3;
  localparam int unsigned STB_OR  = 2;
  localparam int unsigned STB_NOT = 1;
  localparam int unsigned STB_XOR = 0;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StDrive   = 3'd1;
  localparam logic [2:0] StSettle  = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StResp    = 3'd4;

endpackage

// File: rtl/calc_op_decode.sv
// Combinational opcode decoder: 3-bit opcode to one-hot strobe bus plus clear.
module calc_op_decode
  import calc_pkg::*;
(
  input  logic [2:0]        op_i,
  output logic [NumStb-1:0] ops_o,
  output logic              clr_o
);

  always_comb begin
    ops_o = '0;
    clr_o = 1'b0;
    unique case (op_i)
      OP_ADD:  ops_o[STB_ADD] = 1'b1;
      OP_SUB:  ops_o[STB_SUB] = 1'b1;
      OP_MUL:  ops_o[STB_MUL] = 1'b1;
      OP_AND:  ops_o[STB_AND] = 1'b1;
      OP_OR:   ops_o[STB_OR]  = 1'b1;
      OP_NOT:  ops_o[STB_NOT] = 1'b1;
      OP_XOR:  ops_o[STB_XOR] = 1'b1;
      OP_CLR:  clr_o          = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_cmd_issuer.sv
// Command initiator for the calculator: accepts one command, pulses its strobe for one cycle,
// waits for the result register, and returns the captured result over a response handshake.
module calc_cmd_issuer
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [7:0]        cmd_a_i,
  input  logic [7:0]        cmd_b_i,
  input  logic              cmd_uas_i,
  output logic [7:0]        alu_in1_o,
  output logic [7:0]        alu_in2_o,
  output logic [NumStb-1:0] alu_ops_o,
  output logic              alu_uas_o,
  output logic              alu_clr_o,
  input  logic [7:0]        alu_res_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_data_o,
  output logic [2:0]        rsp_op_o,
  output logic [CNT_W-1:0]  done_cnt_o
);

  // Settle counter loads SETTLE-1 on leaving DRIVE and counts down to zero.
  localparam logic [3:0] SettleLast = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  logic [2:0]        state_q, state_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [7:0]        alu_in1_q, alu_in1_d;
  logic [7:0]        alu_in2_q, alu_in2_d;
  logic [NumStb-1:0] alu_ops_q, alu_ops_d;
  logic              alu_uas_q, alu_uas_d;
  logic              alu_clr_q, alu_clr_d;
  logic [2:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic [NumStb-1:0] dec_ops;
  logic              dec_clr;

  calc_op_decode u_op_decode (
    .op_i  (cmd_op_i),
    .ops_o (dec_ops),
    .clr_o (dec_clr)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cmd_ready_d  = cmd_ready_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_ops_d    = alu_ops_q;
    alu_uas_d    = alu_uas_q;
    alu_clr_d    = alu_clr_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_op_d     = rsp_op_q;
    done_cnt_d   = done_cnt_q;

    case (state_q)
      StIdle: begin
        // cmd_ready rises one edge after reset; accepting needs it already high.
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          alu_in1_d   = cmd_a_i;
          alu_in2_d   = cmd_b_i;
          alu_uas_d   = cmd_uas_i;
          alu_ops_d   = dec_ops;
          alu_clr_d   = dec_clr;
          op_d        = cmd_op_i;
          cmd_ready_d = 1'b0;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        alu_ops_d = '0;
        alu_clr_d = 1'b0;
        if (SETTLE > 0) begin
          settle_cnt_d = SettleLast;
          state_d      = StSettle;
        end else begin
          state_d = StCapture;
        end
      end
      StSettle: begin
        if (settle_cnt_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      StCapture: begin
        rsp_data_d  = alu_res_i;
        rsp_op_d    = op_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        alu_ops_d   = '0;
        alu_clr_d   = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      settle_cnt_q <= 4'd0;
      cmd_ready_q  <= 1'b0;
      alu_in1_q    <= 8'h00;
      alu_in2_q    <= 8'h00;
      alu_ops_q    <= '0;
      alu_uas_q    <= 1'b0;
      alu_clr_q    <= 1'b0;
      op_q         <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_op_q     <= 3'd0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_ops_q    <= alu_ops_d;
      alu_uas_q    <= alu_uas_d;
      alu_clr_q    <= alu_clr_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_op_q     <= rsp_op_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign alu_in1_o   = alu_in1_q;
  assign alu_in2_o   = alu_in2_q;
  assign alu_ops_o   = alu_ops_q;
  assign alu_uas_o   = alu_uas_q;
  assign alu_clr_o   = alu_clr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_op_o    = rsp_op_q;
  assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Directed bench for calc_cmd_issuer: one instance with SETTLE=0 and one with SETTLE=3,
// each driving a behavioural model of the calculator result register.
module tb_calc_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       cmd_uas;

  logic       cmd_valid, cmd_ready, rsp_ready, rsp_valid, alu_uas, alu_clr;
  logic [7:0] alu_in1, alu_in2, alu_res, rsp_data;
  logic [6:0] alu_ops;
  logic [2:0] rsp_op;
  logic [7:0] done_cnt;

  logic       cmd_valid_s, cmd_ready_s, rsp_ready_s, rsp_valid_s, alu_uas_s, alu_clr_s;
  logic [7:0] alu_in1_s, alu_in2_s, alu_res_s, rsp_data_s;
  logic [6:0] alu_ops_s;
  logic [2:0] rsp_op_s;
  logic [7:0] done_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_cmd_issuer #(.SETTLE(0), .CNT_W(8)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid_i (cmd_valid), .cmd_ready_o (cmd_ready), .cmd_op_i (cmd_op),
    .cmd_a_i (cmd_a), .cmd_b_i (cmd_b), .cmd_uas_i (cmd_uas),
    .alu_in1_o (alu_in1), .alu_in2_o (alu_in2), .alu_ops_o (alu_ops),
    .alu_uas_o (alu_uas), .alu_clr_o (alu_clr), .alu_res_i (alu_res),
    .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready), .rsp_data_o (rsp_data),
    .rsp_op_o (rsp_op), .done_cnt_o (done_cnt)
  );

  calc_cmd_issuer #(.SETTLE(3), .CNT_W(8)) u_dut_s3 (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid_i (cmd_valid_s), .cmd_ready_o (cmd_ready_s), .cmd_op_i (cmd_op),
    .cmd_a_i (cmd_a), .cmd_b_i (cmd_b), .cmd_uas_i (cmd_uas),
    .alu_in1_o (alu_in1_s), .alu_in2_o (alu_in2_s), .alu_ops_o (alu_ops_s),
    .alu_uas_o (alu_uas_s), .alu_clr_o (alu_clr_s), .alu_res_i (alu_res_s),
    .rsp_valid_o (rsp_valid_s), .rsp_ready_i (rsp_ready_s), .rsp_data_o (rsp_data_s),
    .rsp_op_o (rsp_op_s), .done_cnt_o (done_cnt_s)
  );

  // Calculator result register: NOT acts on the saved result when uas=1, else on operand 1.
  function automatic logic [7:0] calc(input logic [6:0] ops, input logic [7:0] in1,
                                      input logic [7:0] in2, input logic uas,
                                      input logic [7:0] res);
    logic [7:0] op2;
    logic [7:0] r;
    op2 = uas ? res : in2;
    r   = res;
    if (ops[6]) r = in1 + op2;
    if (ops[5]) r = in1 - op2;
    if (ops[4]) r = in1 * op2;
    if (ops[3]) r = in1 & op2;
    if (ops[2]) r = in1 | op2;
    if (ops[1]) r = ~(uas ? res : in1);
    if (ops[0]) r = in1 ^ op2;
    return r;
  endfunction

  initial alu_res = 8'h00;
  initial alu_res_s = 8'h00;

  always @(posedge clk) begin
    if (alu_clr) alu_res <= 8'h00;
    else if (|alu_ops) alu_res <= calc(alu_ops, alu_in1, alu_in2, alu_uas, alu_res);
  end

  always @(posedge clk) begin
    if (alu_clr_s) alu_res_s <= 8'h00;
    else if (|alu_ops_s) alu_res_s <= calc(alu_ops_s, alu_in1_s, alu_in2_s, alu_uas_s, alu_res_s);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot", 32'($countones({alu_ops, alu_clr}) <= 1), 32'd1);
    chk("onehot_s3", 32'($countones({alu_ops_s, alu_clr_s}) <= 1), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full command on the SETTLE=0 instance with rsp_ready held high.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic uas, input logic [6:0] eops, input logic [7:0] edata,
                       input string tag);
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_uas = uas; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_ops"}, 32'(alu_ops), 32'(eops));
    chk({tag, "_uas"}, 32'(alu_uas), 32'(uas));
    chk({tag, "_in2"}, 32'(alu_in2), 32'(b));
    tick();
    chk({tag, "_ops_off"}, 32'(alu_ops), 32'd0);
    tick();
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(edata));
    chk({tag, "_op"}, 32'(rsp_op), 32'(op));
    tick();
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  // Full command on the SETTLE=3 instance, checking accept-to-response latency.
  task automatic issue_s3(input logic [2:0] op, input logic [7:0] a, input logic uas,
                          input logic [6:0] eops, input logic eclr, input logic [7:0] edata,
                          input string tag);
    int n;
    chk({tag, "_rdy"}, 32'(cmd_ready_s), 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = 8'h55; cmd_uas = uas; cmd_valid_s = 1'b1;
    tick();
    cmd_valid_s = 1'b0;
    chk({tag, "_ops"}, 32'(alu_ops_s), 32'(eops));
    chk({tag, "_clr"}, 32'(alu_clr_s), 32'(eclr));
    tick();
    chk({tag, "_clr_off"}, 32'(alu_clr_s), 32'd0);
    n = 1;
    while (!rsp_valid_s && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_data"}, 32'(rsp_data_s), 32'(edata));
    chk({tag, "_op"}, 32'(rsp_op_s), 32'(op));
    tick();
    chk({tag, "_ready_back"}, 32'(cmd_ready_s), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_valid_s = 1'b0;
    rsp_ready = 1'b1; rsp_ready_s = 1'b1;
    cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_uas = 1'b0;

    repeat (3) tick();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_ops", 32'(alu_ops), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_before", 32'(cmd_ready), 32'd0);
    tick();
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_rspv", 32'(rsp_valid), 32'd0);
    chk("rel_in1", 32'(alu_in1), 32'd0);
    chk("rel_clr", 32'(alu_clr), 32'd0);
    chk("rel_data", 32'(rsp_data), 32'd0);

    issue(3'd0, 8'h12, 8'h34, 1'b0, 7'b1000000, 8'h46, "add");
    chk("add_cnt", 32'(done_cnt), 32'd1);
    chk("add_ready", 32'(cmd_ready), 32'd1);

    // Backpressure: XOR response held while a second command waits.
    rsp_ready = 1'b0;
    cmd_op = 3'd6; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_uas = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("xor_ops", 32'(alu_ops), 32'b0000001);
    tick(); tick();
    chk("xor_rspv", 32'(rsp_valid), 32'd1);
    chk("xor_data", 32'(rsp_data), 32'hCC);
    cmd_op = 3'd0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rspv", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'hCC);
      chk("bp_op", 32'(rsp_op), 32'd6);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_ops", 32'(alu_ops), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_rspv", 32'(rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(cmd_ready), 32'd1);
    chk("bp_hs_noacc", 32'(alu_ops), 32'd0);
    chk("bp_hs_cnt", 32'(done_cnt), 32'd2);
    tick();
    cmd_valid = 1'b0;
    chk("bp_acc_ops", 32'(alu_ops), 32'b1000000);
    tick(); tick();
    chk("bp_acc_data", 32'(rsp_data), 32'h02);
    tick();
    chk("bp_acc_cnt", 32'(done_cnt), 32'd3);

    // Use-saved chain.
    issue(3'd0, 8'h05, 8'h03, 1'b0, 7'b1000000, 8'h08, "chain_add");
    issue(3'd3, 8'h0E, 8'hFF, 1'b1, 7'b0001000, 8'h08, "chain_and");
    chk("chain_cnt", 32'(done_cnt), 32'd5);

    // Abort during DRIVE of a MUL.
    cmd_op = 3'd2; cmd_a = 8'h03; cmd_b = 8'h05; cmd_uas = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_drive", 32'(alu_ops), 32'b0010000);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ops", 32'(alu_ops), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    chk("abort_cnt", 32'(done_cnt), 32'd0);
    repeat (2) tick();
    chk("abort_rspv", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_rel_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rel_rspv", 32'(rsp_valid), 32'd0);
    issue(3'd2, 8'h03, 8'h05, 1'b0, 7'b0010000, 8'h0F, "mul");
    chk("mul_cnt", 32'(done_cnt), 32'd1);

    // SETTLE=3 instance: CLR then NOT on the saved (cleared) result.
    issue_s3(3'd7, 8'h00, 1'b0, 7'b0000000, 1'b1, 8'h00, "s3_clr");
    issue_s3(3'd5, 8'h00, 1'b1, 7'b0000010, 1'b0, 8'hFF, "s3_not");
    chk("s3_cnt", 32'(done_cnt_s), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_cmd_issuer.md
Name: calc_cmd_issuer

Overview:
Front-end initiator for the 8-bit calculator control unit. It accepts encoded commands (opcode, two operands, use-saved flag) over a valid/ready handshake. For each command it drives the one-hot operation strobes and operands into the calculator, waits for the result register to capture, then returns the result over a second valid/ready handshake. It is the master side of the calculator's strobe interface; one command is in flight at a time.

Parameters:
SETTLE, 0, extra idle cycles between result-register capture and response latch (0..15)
CNT_W, 8, width of the completed-command counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  issuer can accept a command
cmd_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 NOT, 6 XOR, 7 CLR
cmd_a  in  8  operand 1
cmd_b  in  8  operand 2, ignored when cmd_uas=1 or op is NOT/CLR
cmd_uas  in  1  use saved result in place of operand 2
alu_in1  out  8  operand 1 to calculator
alu_in2  out  8  operand 2 to calculator
alu_ops  out  7  one-hot strobes {add,sub,mul,and,or,not,xor}
alu_uas  out  1  use-saved flag to calculator
alu_clr  out  1  calculator result-register clear (its active-high rst)
alu_res  in  8  calculator result register output
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  captured result
rsp_op  out  3  opcode of the command that produced rsp_data
done_cnt  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. cmd_ready, rsp_valid, alu_ops, alu_uas and alu_clr are 0. alu_in1, alu_in2, rsp_data, rsp_op and done_cnt are 0. The settle counter is 0.
- All outputs are registered. cmd_ready rises on the first clk edge after rst_n deasserts.
- The state machine has states IDLE, DRIVE, SETTLE, CAPTURE and RESP.
- IDLE: cmd_ready=1. When cmd_valid&&cmd_ready is high at an edge:
  - latch the operands into alu_in1/alu_in2 and cmd_uas into alu_uas;
  - assert exactly one alu_ops bit, or alu_clr for op 7;
  - drop cmd_ready;
  - go to DRIVE.
- DRIVE lasts exactly one cycle with the strobe high; the calculator captures on the edge that ends DRIVE. On that edge all strobes and alu_clr return to 0; alu_in1/alu_in2/alu_uas hold. Go to SETTLE if SETTLE>0, otherwise CAPTURE.
- SETTLE counts SETTLE cycles, then goes to CAPTURE.
- CAPTURE lasts one cycle. At its ending edge: rsp_data<=alu_res, rsp_op<=opcode, rsp_valid<=1; go to RESP.
- RESP: rsp_valid, rsp_data and rsp_op are held stable until rsp_valid&&rsp_ready at an edge. On that edge: rsp_valid<=0, done_cnt<=done_cnt+1 (wraps), cmd_ready<=1, go to IDLE.
- Latency with SETTLE=0: command accepted at edge k gives rsp_valid high after edge k+2. With rsp_ready tied high, the minimum command period is 4 cycles.
- cmd_valid while cmd_ready=0 is ignored; the source must hold it. No command is queued.
- Strobe one-hotness: at most one bit of {alu_ops, alu_clr} is high in any cycle, and only during DRIVE.
- CLR returns the captured value (expected 0) like any other op.
- Operand 2 is forwarded unmodified in every case; the calculator's uas mux decides whether it is used.
- rst_n asserted mid-command (any state) aborts it: strobes drop immediately, no response is produced, done_cnt resets.
- The result register must not be read outside CAPTURE.

Decomposition:
- Shared package calc_pkg holds:
  - opcode localparams OP_ADD..OP_CLR (3-bit);
  - the strobe bit-index constants matching the calculator's {add,sub,mul,and,or,not,xor} order;
  - state encoding localparams.
- Natural sub-module: calc_op_decode, a combinational 3-bit opcode to {7-bit one-hot, clr}, shared with the future keypad front-end.
- The FSM, settle counter and response register stay in calc_cmd_issuer.

Test Plan:
- Reset release: after rst_n rises, cmd_ready=1 on the next edge; all other outputs stay 0.
- ADD a=8'h12 b=8'h34, SETTLE=0, bench models the calculator result register as res=a+b captured on alu_ops[6] -> exactly one cycle with alu_ops=7'b1000000; rsp_valid high 2 edges after accept; rsp_data=8'h46, rsp_op=0; done_cnt=1.
- Backpressure: XOR 8'hF0^8'h3C with rsp_ready held low for 5 cycles -> rsp_data=8'hCC stable, cmd_ready=0 throughout; a cmd_valid during this window is not accepted until the cycle after the rsp handshake.
- Use-saved chain: ADD 8'h05+8'h03, then AND uas=1 a=8'h0E b=8'hFF -> alu_uas=1 during the second DRIVE; rsp_data=8'h08&8'h0E=8'h08.
- CLR then NOT uas=1 with SETTLE=3 -> alu_clr pulses one cycle; CAPTURE occurs 4 cycles after DRIVE; responses are 8'h00 then 8'hFF.
- Abort: assert rst_n low during DRIVE of a MUL -> alu_ops=0 immediately (asynchronous), no rsp_valid, done_cnt=0, and the next command completes normally.
